// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: reads one frame from a synchronous RAM in raster order and streams it with sof/eol tags; define BORDER_PAD_EN to add a zero border ring
module pixel_frame_streamer #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eol
);
`ifdef BORDER_PAD_EN
  localparam int OUT_W = IMG_W + 2;
  localparam int OUT_H = IMG_H + 2;
`else
  localparam int OUT_W = IMG_W;
  localparam int OUT_H = IMG_H;
`endif
  localparam int XW = $clog2(OUT_W);
  localparam int YW = $clog2(OUT_H);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_W-1:0] addr;
  logic [1:0] count, used, lvl;
  logic infl, infl_sof, infl_eol;
`ifdef BORDER_PAD_EN
  logic infl_pad;
`endif
  logic [PIX_W-1:0] d0, d1, push_data;
  logic sof0, sof1, eol0, eol1;
  logic issue, pad, last, pop, push;
  // Slot issue, FIFO handshake, FSM next state and outputs. Issue looks at
  // occupancy after this cycle's pop so a full-rate stream keeps flowing.
  always_comb begin
    pix_valid = count != 2'd0;
    pix_data = d0;
    pix_sof = sof0 && pix_valid;
    pix_eol = eol0 && pix_valid;
    pop = pix_valid && pix_ready;
    push = infl;
    lvl = count - 2'(pop);
    used = lvl + 2'(infl);
    issue = (state == RUN || (state == IDLE && start)) && used < 2'd2;
    last = x == X_LAST && y == Y_LAST;
`ifdef BORDER_PAD_EN
    pad = x == '0 || x == X_LAST || y == '0 || y == Y_LAST;
    push_data = infl_pad ? '0 : mem_rd_data;
`else
    pad = 1'b0;
    push_data = mem_rd_data;
`endif
    mem_rd_en = issue && !pad;
    mem_addr = addr;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN ? (issue && last ? DRAIN : RUN) :
              state == DRAIN ? (!infl && (count == 2'd0 || (count == 2'd1 && pop)) ? DONE : DRAIN) :
              IDLE;
  end
  // State register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Raster position and RAM address; both wrap to zero after the last slot
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      y <= '0;
      addr <= '0;
    end else if (issue) begin
      x <= x == X_LAST ? '0 : x + 1'b1;
      if (x == X_LAST) y <= y == Y_LAST ? '0 : y + 1'b1;
      addr <= last ? '0 : addr + ADDR_W'(mem_rd_en);
    end
  // One-deep in-flight stage carrying the tags computed at issue time
  always_ff @(posedge clk)
    if (rst) begin
      infl <= 1'b0;
      infl_sof <= 1'b0;
      infl_eol <= 1'b0;
`ifdef BORDER_PAD_EN
      infl_pad <= 1'b0;
`endif
    end else begin
      infl <= issue;
      infl_sof <= x == '0 && y == '0;
      infl_eol <= x == X_LAST;
`ifdef BORDER_PAD_EN
      infl_pad <= pad;
`endif
    end
  // Two-entry shift FIFO; d0 is the head presented on the stream
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      sof0 <= 1'b0;
      sof1 <= 1'b0;
      eol0 <= 1'b0;
      eol1 <= 1'b0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) begin
        d0 <= d1;
        sof0 <= sof1;
        eol0 <= eol1;
      end
      if (push && lvl == 2'd0) begin
        d0 <= push_data;
        sof0 <= infl_sof;
        eol0 <= infl_eol;
      end
      if (push && lvl == 2'd1) begin
        d1 <= push_data;
        sof1 <= infl_sof;
        eol1 <= infl_eol;
      end
    end
endmodule
